// File: rtl/fetch_buffer.sv
// Fetch-to-dispatch instruction queue: WAYS-wide circular FIFO with
// contiguous enqueue from fetch and in-order dequeue to dispatch.

module fetch_buffer_lane #(
    parameter int LANE  = 0,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic [PW-1:0]                head,
    input  logic [CW-1:0]                count,
    input  logic [DEPTH-1:0][XLEN-1:0]   pc_q,
    input  logic [DEPTH-1:0][XLEN-1:0]   npc_q,
    input  logic [DEPTH-1:0][XLEN-1:0]   inst_q,
    output logic                         valid,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              npc,
    output logic [XLEN-1:0]              inst
);
    logic [PW-1:0] idx;

    assign idx   = head + PW'(LANE);
    assign valid = CW'(LANE) < count;
    assign pc    = pc_q[idx];
    assign npc   = npc_q[idx];
    assign inst  = inst_q[idx];
endmodule

module fetch_buffer #(
    parameter int WAYS  = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1,
    localparam int DW   = $clog2(WAYS) + 1,
    localparam int SW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        branch_flush_en,
    input  logic [WAYS-1:0]             fetch_valid,
    input  logic [WAYS-1:0][XLEN-1:0]   fetch_pc,
    input  logic [WAYS-1:0][XLEN-1:0]   fetch_npc,
    input  logic [WAYS-1:0][XLEN-1:0]   fetch_inst,
    input  logic [DW-1:0]               dispatch_num,
    output logic [WAYS-1:0]             out_valid,
    output logic [WAYS-1:0][XLEN-1:0]   out_pc,
    output logic [WAYS-1:0][XLEN-1:0]   out_npc,
    output logic [WAYS-1:0][XLEN-1:0]   out_inst,
    output logic                        stall_enable,
    output logic [SW-1:0]               first_stall_idx,
    output logic [CW-1:0]               count,
    output logic                        full,
    output logic                        empty
);
    logic [PW-1:0]              head, tail;
    logic [DEPTH-1:0][XLEN-1:0] pc_q, npc_q, inst_q;
    logic [DW-1:0]              n_in;
    logic [CW-1:0]              free, n_in_c, accepted, n_out;
    logic                       run;

    // Only the unbroken run of valid ways from way 0 is eligible.
    always_comb begin
        n_in = '0;
        run  = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            if (run && fetch_valid[i]) n_in = n_in + DW'(1);
            else                       run  = 1'b0;
        end
    end

    // Space is judged on the registered count, so dequeues this cycle
    // do not make room for enqueues this cycle.
    assign free     = CW'(DEPTH) - count;
    assign n_in_c   = CW'(n_in);
    assign accepted = (n_in_c <= free) ? n_in_c : free;
    assign n_out    = (CW'(dispatch_num) <= count) ? CW'(dispatch_num) : count;

    assign stall_enable    = !branch_flush_en && (n_in == DW'(WAYS)) && (accepted < CW'(WAYS));
    assign first_stall_idx = stall_enable ? SW'(accepted) : '0;
    assign full            = (count == CW'(DEPTH));
    assign empty           = (count == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (branch_flush_en) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_out);
            tail  <= tail + PW'(accepted);
            count <= count + accepted - n_out;
        end
    end

    always_ff @(posedge clock) begin
        if (!branch_flush_en) begin
            for (int i = 0; i < WAYS; i++) begin
                if (CW'(i) < accepted) begin
                    pc_q[tail + PW'(i)]   <= fetch_pc[i];
                    npc_q[tail + PW'(i)]  <= fetch_npc[i];
                    inst_q[tail + PW'(i)] <= fetch_inst[i];
                end
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_lane
        fetch_buffer_lane #(.LANE(w), .DEPTH(DEPTH), .XLEN(XLEN)) u_lane (
            .head   (head),
            .count  (count),
            .pc_q   (pc_q),
            .npc_q  (npc_q),
            .inst_q (inst_q),
            .valid  (out_valid[w]),
            .pc     (out_pc[w]),
            .npc    (out_npc[w]),
            .inst   (out_inst[w])
        );
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed and random stimulus for fetch_buffer, checked against a
// queue-based reference model.

module tb_fetch_buffer;
    localparam int WAYS  = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [XLEN-1:0] inst;
    } ent_t;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      branch_flush_en;
    logic [WAYS-1:0]           fetch_valid;
    logic [WAYS-1:0][XLEN-1:0] fetch_pc, fetch_npc, fetch_inst;
    logic [1:0]                dispatch_num;
    logic [WAYS-1:0]           out_valid;
    logic [WAYS-1:0][XLEN-1:0] out_pc, out_npc, out_inst;
    logic                      stall_enable;
    logic [0:0]                first_stall_idx;
    logic [3:0]                count;
    logic                      full, empty;

    ent_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    fetch_buffer #(.WAYS(WAYS), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock           (clock),
        .reset           (reset),
        .branch_flush_en (branch_flush_en),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .fetch_npc       (fetch_npc),
        .fetch_inst      (fetch_inst),
        .dispatch_num    (dispatch_num),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_npc         (out_npc),
        .out_inst        (out_inst),
        .stall_enable    (stall_enable),
        .first_stall_idx (first_stall_idx),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = q.size();
        chk("count", 64'(count), 64'(sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("full",  64'(full),  64'(sz == DEPTH));
        for (int i = 0; i < WAYS; i++) begin
            chk("out_valid", 64'(out_valid[i]), 64'(i < sz));
            if (i < sz) begin
                chk("out_pc",   64'(out_pc[i]),   64'(q[i].pc));
                chk("out_npc",  64'(out_npc[i]),  64'(q[i].npc));
                chk("out_inst", 64'(out_inst[i]), 64'(q[i].inst));
            end
        end
    endtask

    // Called just after a posedge: drive, check fetch handshake, clock, check state.
    task automatic cyc(input logic [1:0] fv, input logic [31:0] pc0,
                       input logic [1:0] dn, input logic fl);
        int   nin, fr, acc, nout;
        bit   run, est;
        ent_t e;
        fetch_valid     = fv;
        dispatch_num    = dn;
        branch_flush_en = fl;
        for (int i = 0; i < WAYS; i++) begin
            fetch_pc[i]   = pc0 + 32'(4 * i);
            fetch_npc[i]  = pc0 + 32'(4 * i + 4);
            fetch_inst[i] = $urandom;
        end
        #1;
        nin = 0;
        run = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            if (run && fv[i]) nin++;
            else run = 1'b0;
        end
        fr  = DEPTH - q.size();
        acc = (nin < fr) ? nin : fr;
        est = !fl && (nin == WAYS) && (acc < WAYS);
        chk("stall_enable",    64'(stall_enable),    64'(est));
        chk("first_stall_idx", 64'(first_stall_idx), est ? 64'(acc) : 64'd0);
        @(posedge clock);
        if (fl) q.delete();
        else begin
            nout = (int'(dn) < q.size()) ? int'(dn) : q.size();
            repeat (nout) void'(q.pop_front());
            for (int i = 0; i < acc; i++) begin
                e.pc   = fetch_pc[i];
                e.npc  = fetch_npc[i];
                e.inst = fetch_inst[i];
                q.push_back(e);
            end
        end
        #1;
        check_state();
    endtask

    initial begin
        reset           = 1'b0;
        branch_flush_en = 1'b0;
        fetch_valid     = '0;
        fetch_pc        = '0;
        fetch_npc       = '0;
        fetch_inst      = '0;
        dispatch_num    = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full",  64'(full),  64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_stall", 64'(stall_enable), 64'd0);
        chk("rst_fsi",   64'(first_stall_idx), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_state();

        // Fill to full with no dispatch, then try one more pair.
        for (int k = 0; k < 4; k++) cyc(2'b11, 32'(8 * k), 2'd0, 1'b0);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_pc0",  64'(out_pc[0]), 64'd0);
        cyc(2'b11, 32'd32, 2'd0, 1'b0);

        // Full plus dispatch: nothing accepted, count drops by 2.
        cyc(2'b11, 32'd32, 2'd2, 1'b0);
        chk("deq_full_count", 64'(count), 64'd6);
        chk("deq_full_pc0",   64'(out_pc[0]), 64'd8);

        // Partial accept at count 7.
        cyc(2'b01, 32'd32, 2'd0, 1'b0);
        cyc(2'b11, 32'd40, 2'd0, 1'b0);
        chk("partial_count", 64'(count), 64'd8);
        chk("partial_tail",  64'(q[$].pc), 64'd40);
        repeat (4) cyc(2'b00, 32'd0, 2'd2, 1'b0);
        chk("drained", 64'(empty), 64'd1);

        // Streaming wraps both pointers.
        for (int k = 0; k < 12; k++) cyc(2'b11, 32'(256 + 8 * k), 2'd2, 1'b0);
        chk("stream_count", 64'(count), 64'd2);

        // Flush beats simultaneous enqueue/dequeue.
        cyc(2'b11, 32'd512, 2'd0, 1'b0);
        cyc(2'b01, 32'd520, 2'd0, 1'b0);
        chk("preflush_count", 64'(count), 64'd5);
        cyc(2'b11, 32'd524, 2'd2, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream.
        cyc(2'b11, 32'd600, 2'd0, 1'b0);
        cyc(2'b11, 32'd608, 2'd1, 1'b0);
        fetch_valid  = '0;
        dispatch_num = '0;
        reset        = 1'b0;
        #2;
        q.delete();
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_stall", 64'(stall_enable), 64'd0);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_state();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cyc(2'($urandom), {$urandom_range(0, 1023), 2'b00} + 32'd0,
                2'($urandom_range(0, 2)), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
